// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port controller: arbitrates IF fetches against MEM loads/stores
// (MEM wins), splits each access into byte transfers and assembles little-endian words.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_SEL_HI  = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    input  logic                  if_clear_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  read_req_in,
    input  logic                  write_req_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [31:0]           mem_val_in,
    input  logic [2:0]            store_len,
    output logic                  mem_done_out,
    output logic [31:0]           mem_val_read_out,
    output logic [1:0]            memctrl_busy_out,
    input  logic [7:0]            ram_din_in,
    output logic [7:0]            ram_dout_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic                  ram_wr_out,
    input  logic                  io_buffer_full_in
);

    typedef enum logic [2:0] {IDLE, IFR, MRD, MWR, DONE} state_t;

    state_t                state, state_n;
    logic [2:0]            cnt, cnt_n, len, len_n, cnt_inc;
    logic [ADDR_WIDTH-1:0] base, base_n, addr_n;
    logic [31:0]           wdata, wdata_n, rbuf, rbuf_n, if_data_n, mem_val_n;
    logic [7:0]            dout_n;
    logic                  wr_q, wr_n, if_done_n, mem_done_n;
    logic [1:0]            busy_n;
    logic                  io_stall, take_mem, take_if, step_read;

    // A store byte aimed at the IO window while the IO FIFO is full is held back.
    assign io_stall   = wr_q && (ram_addr_out[IO_SEL_HI:IO_SEL_HI-1] == 2'b11) && io_buffer_full_in;
    assign ram_wr_out = wr_q && rdy_in && !io_stall;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        len_n      = len;
        base_n     = base;
        wdata_n    = wdata;
        rbuf_n     = rbuf;
        addr_n     = ram_addr_out;
        dout_n     = ram_dout_out;
        wr_n       = wr_q;
        busy_n     = memctrl_busy_out;
        if_done_n  = 1'b0;
        mem_done_n = 1'b0;
        if_data_n  = if_data_out;
        mem_val_n  = mem_val_read_out;
        cnt_inc    = cnt + 3'd1;
        take_mem   = 1'b0;
        take_if    = 1'b0;
        step_read  = 1'b0;

        case (state)
            IDLE: begin
                if (read_req_in || write_req_in)    take_mem = 1'b1;
                else if (if_req_in && !if_clear_in) take_if  = 1'b1;
            end
            IFR: begin
                if (read_req_in || write_req_in) take_mem = 1'b1;
                else if (if_clear_in) begin
                    state_n = IDLE;
                    busy_n  = 2'b00;
                end else step_read = 1'b1;
            end
            MRD: step_read = 1'b1;
            MWR: begin
                if (!io_stall) begin
                    if (cnt_inc < len) begin
                        cnt_n  = cnt_inc;
                        addr_n = base + ADDR_WIDTH'(cnt_inc);
                        dout_n = wdata[{cnt_inc[1:0], 3'b000} +: 8];
                    end else begin
                        wr_n       = 1'b0;
                        mem_done_n = 1'b1;
                        busy_n     = 2'b00;
                        state_n    = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (take_mem) begin
            state_n = write_req_in ? MWR : MRD;
            base_n  = mem_addr_in;
            len_n   = write_req_in ? store_len + 3'd1 : store_len;
            wdata_n = mem_val_in;
            rbuf_n  = '0;
            cnt_n   = '0;
            addr_n  = mem_addr_in;
            dout_n  = write_req_in ? mem_val_in[7:0] : 8'h00;
            wr_n    = write_req_in;
            busy_n  = 2'b10;
        end
        if (take_if) begin
            state_n = IFR;
            base_n  = if_addr_in;
            len_n   = 3'd4;
            rbuf_n  = '0;
            cnt_n   = '0;
            addr_n  = if_addr_in;
            wr_n    = 1'b0;
            busy_n  = 2'b01;
        end
        // Byte cnt was addressed last cycle; one extra edge after the last capture
        // publishes the completed word.
        if (step_read) begin
            if (cnt < len) begin
                rbuf_n[{cnt[1:0], 3'b000} +: 8] = ram_din_in;
                cnt_n  = cnt_inc;
                addr_n = base + ADDR_WIDTH'(cnt_inc);
            end else begin
                busy_n  = 2'b00;
                state_n = DONE;
                if (state == IFR) begin
                    if_done_n = 1'b1;
                    if_data_n = rbuf;
                end else begin
                    mem_done_n = 1'b1;
                    mem_val_n  = rbuf;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            cnt              <= '0;
            len              <= '0;
            base             <= '0;
            wdata            <= '0;
            rbuf             <= '0;
            ram_addr_out     <= '0;
            ram_dout_out     <= '0;
            wr_q             <= 1'b0;
            memctrl_busy_out <= '0;
            if_done_out      <= 1'b0;
            mem_done_out     <= 1'b0;
            if_data_out      <= '0;
            mem_val_read_out <= '0;
        end else if (rdy_in) begin
            state            <= state_n;
            cnt              <= cnt_n;
            len              <= len_n;
            base             <= base_n;
            wdata            <= wdata_n;
            rbuf             <= rbuf_n;
            ram_addr_out     <= addr_n;
            ram_dout_out     <= dout_n;
            wr_q             <= wr_n;
            memctrl_busy_out <= busy_n;
            if_done_out      <= if_done_n;
            mem_done_out     <= mem_done_n;
            if_data_out      <= if_data_n;
            mem_val_read_out <= mem_val_n;
        end
    end

endmodule
